mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  MIPS memory (M) stage plus M->W pipeline register. Consumes the E->M register
//  outputs, performs data-memory loads/stores (word/half/byte), forwards W-stage
//  results into store data, and registers results for write-back. Sits between the
//  E->M register and the GRF write port; one instruction per cycle, no stalls.
// PARAMETERS
//  DM_AW     10    word-address width; DM holds 2**DM_AW 32-bit words (4 KB)
//  RES_W     3     width of the result-source tag (res_*)
// PORTS
//  clk       in   1   clock, all state updates on posedge
//  clr       in   1   synchronous, active-high reset/flush
//  instr_m   in   32  instruction in M
//  a2_m      in   5   rt index of instruction in M (store-data source)
//  a3_m      in   5   destination register index in M
//  res_m     in   3   result source of instruction in M (see package)
//  v2_m      in   32  rt value read in D/E (store data, pre-forwarding)
//  ao_m      in   32  ALU output = byte address for loads/stores
//  pc8_m     in   32  PC+8 of instruction in M
//  instr_w   out  32  registered instr_m
//  a3_w      out  5   registered a3_m
//  res_w     out  3   registered res_m
//  ao_w      out  32  registered ao_m
//  pc8_w     out  32  registered pc8_m
//  dr_w      out  32  registered, already-extended load data
//  wd_w      out  32  combinational GRF write data selected by res_w
// BEHAVIOUR
//  - Latency 1: M-stage values appear on *_w after the next posedge.
//  - clr (sync): all *_w regs <= 0 and every DM word <= 0; clr beats a same-cycle store.
//  - wd_w: RES_DM -> dr_w; RES_PC8 -> pc8_w; RES_ALU -> ao_w; RES_NW -> 0.
//  - Store-data forward: wdata = v2_m, except when a2_m != 0, a2_m == a3_w and
//    res_w != RES_NW, then wdata = wd_w (W result in flight).
//  - Word index = ao_m[DM_AW+1:2]; higher address bits ignored (wrap modulo DM size).
//  - Stores (posedge, clr low): sw writes all 4 bytes; sh writes half ao_m[1]
//    (0 = bits 15:0) with wdata[15:0]; sb writes byte ao_m[1:0] with wdata[7:0].
//    Unwritten bytes unchanged. ao_m[1:0] ignored for sw, ao_m[0] ignored for sh.
//  - Loads read DM combinationally in M: lw word; lh/lhu half ao_m[1] sign/zero-ext;
//    lb/lbu byte ao_m[1:0] sign/zero-ext. Non-load instr -> dr_w <= 0.
//  - Load then store to same word in consecutive cycles: load sees pre-store data;
//    the store is visible to the following cycle's load (write-first on next edge).
//  - No exceptions; unrecognised opcodes neither read nor write DM.
// CONFIGURATION
//  MEM_STAGE_WRITE_LOG_EN defined: on every committed store, $display
//    "%d@%h: *%h <= %h" = ($time, pc8_m-8, {ao_m[31:2],2'b00}, full merged word).
//  Undefined: no display code compiled; RTL behaviour identical.
// STRUCTURE
//  mem_stage_pkg: opcodes OP_LW 100011, OP_LH 100001, OP_LHU 100101, OP_LB 100000,
//    OP_LBU 100100, OP_SW 101011, OP_SH 101001, OP_SB 101000; RES_NW=0, RES_ALU=1,
//    RES_DM=2, RES_PC8=3.
//  Sub-module dm_ram: 2**DM_AW x 32 array, 4-bit byte enable, sync write,
//    async read, sync clear. Decode, forward, extend and W register in mem_stage.
// TESTING
//  1. sw $t0(=0x12345678) @0x10, next lw @0x10 -> dr_w=0x12345678, wd_w same with RES_DM.
//  2. sb 0xAB @0x13 over word 0 at 0x10; lb @0x13 -> 0xFFFFFFAB; lbu -> 0x000000AB;
//     lw @0x10 -> 0xAB000000.
//  3. sh 0x8001 @0x22; lh @0x22 -> 0xFFFF8001; lhu -> 0x00008001; word[0x20]=0x80010000.
//  4. Forward: W has a3_w=8,res_w=RES_ALU,ao_w=0xCAFE; M sw a2_m=8,v2_m=0 -> stored 0xCAFE;
//     same with a2_m=0 -> stored v2_m.
//  5. clr asserted with pending sw -> *_w=0, DM word stays 0; wrap: sw @0x1000 hits word 0.
//  6. jal-like res_m=RES_PC8, pc8_m=0x3008 -> wd_w=0x3008 one cycle later.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared constants, opcodes, result-source tags and load extension for the MIPS M stage.
package mem_stage_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned REG_W  = 5;
   localparam int unsigned OP_W   = 6;
   localparam int unsigned RES_W  = 3;
   localparam int unsigned BE_W   = DATA_W / 8;

   localparam logic [OP_W-1:0] OP_LW  = 6'b100011;
   localparam logic [OP_W-1:0] OP_LH  = 6'b100001;
   localparam logic [OP_W-1:0] OP_LHU = 6'b100101;
   localparam logic [OP_W-1:0] OP_LB  = 6'b100000;
   localparam logic [OP_W-1:0] OP_LBU = 6'b100100;
   localparam logic [OP_W-1:0] OP_SW  = 6'b101011;
   localparam logic [OP_W-1:0] OP_SH  = 6'b101001;
   localparam logic [OP_W-1:0] OP_SB  = 6'b101000;

   typedef enum logic [RES_W-1:0] {
      RES_NW  = 3'd0,
      RES_ALU = 3'd1,
      RES_DM  = 3'd2,
      RES_PC8 = 3'd3
   } res_e;

   // Select and extend the addressed half/byte of a DM word; non-loads yield zero.
   function automatic logic [DATA_W-1:0] load_extend(input logic [OP_W-1:0] op,
                                                     input logic [DATA_W-1:0] word,
                                                     input logic [1:0] off);
      logic [15:0] half;
      logic [7:0]  byt;
      half = off[1] ? word[31:16] : word[15:0];
      byt  = word[{off, 3'b000} +: 8];
      case (op)
         OP_LW:   return word;
         OP_LH:   return {{16{half[15]}}, half};
         OP_LHU:  return {16'h0000, half};
         OP_LB:   return {{24{byt[7]}}, byt};
         OP_LBU:  return {24'h000000, byt};
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// M-stage inputs (from the E->M register) and W-stage outputs of the memory stage.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [DATA_W-1:0] instr_m;
   logic [REG_W-1:0]  a2_m;
   logic [REG_W-1:0]  a3_m;
   logic [RES_W-1:0]  res_m;
   logic [DATA_W-1:0] v2_m;
   logic [DATA_W-1:0] ao_m;
   logic [DATA_W-1:0] pc8_m;

   logic [DATA_W-1:0] instr_w;
   logic [REG_W-1:0]  a3_w;
   logic [RES_W-1:0]  res_w;
   logic [DATA_W-1:0] ao_w;
   logic [DATA_W-1:0] pc8_w;
   logic [DATA_W-1:0] dr_w;
   logic [DATA_W-1:0] wd_w;

   modport master (
      output instr_m, a2_m, a3_m, res_m, v2_m, ao_m, pc8_m,
      input  instr_w, a3_w, res_w, ao_w, pc8_w, dr_w, wd_w
   );

   modport slave (
      input  instr_m, a2_m, a3_m, res_m, v2_m, ao_m, pc8_m,
      output instr_w, a3_w, res_w, ao_w, pc8_w, dr_w, wd_w
   );

endinterface

// File: rtl/mem_stage_dm_ram.sv
// Data memory: word array with byte-enable synchronous write, async read, sync clear.
module mem_stage_dm_ram
   import mem_stage_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic              clk,
   input  logic              clr,
   input  logic [AW-1:0]     idx_i,
   input  logic [BE_W-1:0]   be_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned DEPTH = 2 ** AW;

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Clear wins over a same-cycle write.
   always_ff @(posedge clk) begin
      if (clr) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int unsigned b = 0; b < BE_W; b++) begin
            if (be_i[b]) begin
               mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage plus M->W register: store forwarding, lane decode, load extension.
// Optional store trace enabled by defining MEM_STAGE_WRITE_LOG_EN.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned DM_AW = 10
) (
   input  logic        clk,
   input  logic        clr,
   mem_stage_if.slave  bus
);

   logic [OP_W-1:0]   op;
   logic              fwd;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] wpos;
   logic [BE_W-1:0]   be;
   logic [DATA_W-1:0] rdata;
   logic [DATA_W-1:0] dr_d;

   logic [DATA_W-1:0] instr_q;
   logic [REG_W-1:0]  a3_q;
   logic [RES_W-1:0]  res_q;
   logic [DATA_W-1:0] ao_q;
   logic [DATA_W-1:0] pc8_q;
   logic [DATA_W-1:0] dr_q;
   logic [DATA_W-1:0] wd;

   assign op = bus.instr_m[DATA_W-1 -: OP_W];

   // Forward the in-flight W result into store data; $zero is never forwarded.
   assign fwd   = (bus.a2_m != '0) && (bus.a2_m == a3_q) && (res_q != RES_NW);
   assign wdata = fwd ? wd : bus.v2_m;

   // Byte-lane enables with store data replicated onto every lane.
   always_comb begin
      be   = '0;
      wpos = '0;
      case (op)
         OP_SW: begin
            be   = 4'b1111;
            wpos = wdata;
         end
         OP_SH: begin
            be   = bus.ao_m[1] ? 4'b1100 : 4'b0011;
            wpos = {2{wdata[15:0]}};
         end
         OP_SB: begin
            be   = 4'b0001 << bus.ao_m[1:0];
            wpos = {4{wdata[7:0]}};
         end
         default: ;
      endcase
   end

   mem_stage_dm_ram #(
      .AW (DM_AW)
   ) u_dm_ram (
      .clk     (clk),
      .clr     (clr),
      .idx_i   (bus.ao_m[DM_AW+1:2]),
      .be_i    (be),
      .wdata_i (wpos),
      .rdata_o (rdata)
   );

   assign dr_d = load_extend(op, rdata, bus.ao_m[1:0]);

   always_ff @(posedge clk) begin
      if (clr) begin
         instr_q <= '0;
         a3_q    <= '0;
         res_q   <= '0;
         ao_q    <= '0;
         pc8_q   <= '0;
         dr_q    <= '0;
      end else begin
         instr_q <= bus.instr_m;
         a3_q    <= bus.a3_m;
         res_q   <= bus.res_m;
         ao_q    <= bus.ao_m;
         pc8_q   <= bus.pc8_m;
         dr_q    <= dr_d;
      end
   end

   // GRF write data; undefined result tags write zero.
   always_comb begin
      wd = '0;
      case (res_q)
         RES_DM:  wd = dr_q;
         RES_PC8: wd = pc8_q;
         RES_ALU: wd = ao_q;
         default: wd = '0;
      endcase
   end

   assign bus.instr_w = instr_q;
   assign bus.a3_w    = a3_q;
   assign bus.res_w   = res_q;
   assign bus.ao_w    = ao_q;
   assign bus.pc8_w   = pc8_q;
   assign bus.dr_w    = dr_q;
   assign bus.wd_w    = wd;

`ifdef MEM_STAGE_WRITE_LOG_EN
   logic [DATA_W-1:0] merged;

   always_comb begin
      merged = rdata;
      for (int unsigned b = 0; b < BE_W; b++) begin
         if (be[b]) merged[8*b +: 8] = wpos[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (!clr && (be != '0)) begin
         $display("%d@%h: *%h <= %h", $time, bus.pc8_m - 32'd8,
                  {bus.ao_m[31:2], 2'b00}, merged);
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Randomised and directed bench for mem_stage against a byte-addressed reference model.
module tb_mem_stage;
   import mem_stage_pkg::*;

   localparam int unsigned MEM_BYTES = 4096;

   logic clk = 1'b0;
   logic clr;
   always #5 clk = ~clk;

   mem_stage_if bus ();

   mem_stage dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0]  ref_mem [MEM_BYTES];
   logic [4:0]  w_a3;
   logic [2:0]  w_res;
   logic [31:0] w_wd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [5:0] op, input logic [31:0] addr);
      int unsigned a, w, h;
      logic [15:0] hv;
      logic [7:0]  bv;
      a  = int'(addr[11:0]);
      w  = a & 32'hFFC;
      h  = a & 32'hFFE;
      hv = {ref_mem[h+1], ref_mem[h]};
      bv = ref_mem[a];
      case (op)
         OP_LW:   return {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
         OP_LH:   return {{16{hv[15]}}, hv};
         OP_LHU:  return {16'h0, hv};
         OP_LB:   return {{24{bv[7]}}, bv};
         OP_LBU:  return {24'h0, bv};
         default: return 32'h0;
      endcase
   endfunction

   task automatic ref_clear();
      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
      w_a3  = '0;
      w_res = '0;
      w_wd  = '0;
   endtask

   // One instruction through M; checks everything visible in W one edge later.
   task automatic step(input logic [5:0] op, input logic [4:0] a2, input logic [4:0] a3,
                       input logic [2:0] res, input logic [31:0] v2, input logic [31:0] ao,
                       input logic [31:0] pc8, input string tag);
      logic [31:0] instr, wdata, exp_dr, exp_wd;
      int unsigned a;
      @(negedge clk);
      instr       = {op, 26'($urandom)};
      clr         = 1'b0;
      bus.instr_m = instr;
      bus.a2_m    = a2;
      bus.a3_m    = a3;
      bus.res_m   = res;
      bus.v2_m    = v2;
      bus.ao_m    = ao;
      bus.pc8_m   = pc8;
      wdata  = (a2 != 0 && a2 == w_a3 && w_res != 0) ? w_wd : v2;
      exp_dr = ref_load(op, ao);
      a      = int'(ao[11:0]);
      if (op == OP_SW) begin
         for (int i = 0; i < 4; i++) ref_mem[(a & 32'hFFC) + i] = wdata[8*i +: 8];
      end else if (op == OP_SH) begin
         ref_mem[a & 32'hFFE]         = wdata[7:0];
         ref_mem[(a & 32'hFFE) + 1]   = wdata[15:8];
      end else if (op == OP_SB) begin
         ref_mem[a] = wdata[7:0];
      end
      case (res)
         3'd1:    exp_wd = ao;
         3'd2:    exp_wd = exp_dr;
         3'd3:    exp_wd = pc8;
         default: exp_wd = 32'h0;
      endcase
      @(posedge clk);
      #1;
      chk({tag, ".instr_w"}, bus.instr_w, instr);
      chk({tag, ".a3_w"}, 32'(bus.a3_w), 32'(a3));
      chk({tag, ".res_w"}, 32'(bus.res_w), 32'(res));
      chk({tag, ".ao_w"}, bus.ao_w, ao);
      chk({tag, ".pc8_w"}, bus.pc8_w, pc8);
      chk({tag, ".dr_w"}, bus.dr_w, exp_dr);
      chk({tag, ".wd_w"}, bus.wd_w, exp_wd);
      w_a3  = a3;
      w_res = res;
      w_wd  = exp_wd;
   endtask

   // Flush with an instruction (possibly a store) pending in M.
   task automatic do_clr(input logic [5:0] op, input logic [4:0] a2, input logic [31:0] v2,
                         input logic [31:0] ao, input string tag);
      @(negedge clk);
      clr         = 1'b1;
      bus.instr_m = {op, 26'($urandom)};
      bus.a2_m    = a2;
      bus.a3_m    = 5'd7;
      bus.res_m   = 3'd1;
      bus.v2_m    = v2;
      bus.ao_m    = ao;
      bus.pc8_m   = $urandom;
      @(posedge clk);
      #1;
      chk({tag, ".instr_w"}, bus.instr_w, 32'h0);
      chk({tag, ".a3_w"}, 32'(bus.a3_w), 32'h0);
      chk({tag, ".res_w"}, 32'(bus.res_w), 32'h0);
      chk({tag, ".ao_w"}, bus.ao_w, 32'h0);
      chk({tag, ".pc8_w"}, bus.pc8_w, 32'h0);
      chk({tag, ".dr_w"}, bus.dr_w, 32'h0);
      chk({tag, ".wd_w"}, bus.wd_w, 32'h0);
      ref_clear();
   endtask

   logic [5:0] ops [10];

   initial begin
      ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, 6'b000000, 6'b001111};
      clr = 1'b1;
      bus.instr_m = '0; bus.a2_m = '0; bus.a3_m = '0; bus.res_m = '0;
      bus.v2_m = '0; bus.ao_m = '0; bus.pc8_m = '0;
      ref_clear();

      do_clr(6'b000000, 5'd0, 32'h0, 32'h0, "reset");

      // store word then load it back
      step(OP_SW, 5'd9, 5'd0, 3'd0, 32'h12345678, 32'h10, 32'h3000, "t1.sw");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h10, 32'h3004, "t1.lw");
      chk("t1.dr_const", bus.dr_w, 32'h12345678);
      chk("t1.wd_const", bus.wd_w, 32'h12345678);

      // byte store into a zero word, signed/unsigned byte loads
      step(OP_SW, 5'd9, 5'd0, 3'd0, 32'h0, 32'h10, 32'h3008, "t2.sw0");
      step(OP_SB, 5'd9, 5'd0, 3'd0, 32'h123456AB, 32'h13, 32'h300C, "t2.sb");
      step(OP_LB, 5'd0, 5'd10, 3'd2, 32'h0, 32'h13, 32'h3010, "t2.lb");
      chk("t2.lb_const", bus.dr_w, 32'hFFFFFFAB);
      step(OP_LBU, 5'd0, 5'd10, 3'd2, 32'h0, 32'h13, 32'h3014, "t2.lbu");
      chk("t2.lbu_const", bus.dr_w, 32'h000000AB);
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h10, 32'h3018, "t2.lw");
      chk("t2.lw_const", bus.dr_w, 32'hAB000000);

      // upper half-word store; ao[0] set on the load to show it is ignored
      step(OP_SH, 5'd9, 5'd0, 3'd0, 32'hFFFF8001, 32'h22, 32'h301C, "t3.sh");
      step(OP_LH, 5'd0, 5'd10, 3'd2, 32'h0, 32'h23, 32'h3020, "t3.lh");
      chk("t3.lh_const", bus.dr_w, 32'hFFFF8001);
      step(OP_LHU, 5'd0, 5'd10, 3'd2, 32'h0, 32'h22, 32'h3024, "t3.lhu");
      chk("t3.lhu_const", bus.dr_w, 32'h00008001);
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h20, 32'h3028, "t3.lw");
      chk("t3.lw_const", bus.dr_w, 32'h80010000);

      // W result forwarded into store data, and never for $zero
      step(6'b000000, 5'd0, 5'd8, 3'd1, 32'h0, 32'h0000CAFE, 32'h302C, "t4.alu");
      step(OP_SW, 5'd8, 5'd0, 3'd0, 32'h0, 32'h40, 32'h3030, "t4.sw_fwd");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h40, 32'h3034, "t4.lw_fwd");
      chk("t4.fwd_const", bus.dr_w, 32'h0000CAFE);
      step(6'b000000, 5'd0, 5'd0, 3'd1, 32'h0, 32'h0000CAFE, 32'h3038, "t4.alu0");
      step(OP_SW, 5'd0, 5'd0, 3'd0, 32'h5A5A5A5A, 32'h44, 32'h303C, "t4.sw_r0");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h44, 32'h3040, "t4.lw_r0");
      chk("t4.r0_const", bus.dr_w, 32'h5A5A5A5A);

      // load then store to the same word in back-to-back cycles
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h44, 32'h3044, "ls.lw");
      step(OP_SW, 5'd9, 5'd0, 3'd0, 32'hDEADBEEF, 32'h44, 32'h3048, "ls.sw");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h44, 32'h304C, "ls.lw2");
      chk("ls.const", bus.dr_w, 32'hDEADBEEF);

      // flush beats a pending store; address wraps modulo DM size
      do_clr(OP_SW, 5'd9, 32'h77777777, 32'h80, "t5.clr");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h80, 32'h3050, "t5.lw80");
      chk("t5.clr_const", bus.dr_w, 32'h0);
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h10, 32'h3054, "t5.lw10");
      step(OP_SW, 5'd9, 5'd0, 3'd0, 32'h11112222, 32'h1000, 32'h3058, "t5.sw_wrap");
      step(OP_LW, 5'd0, 5'd10, 3'd2, 32'h0, 32'h0, 32'h305C, "t5.lw_wrap");
      chk("t5.wrap_const", bus.dr_w, 32'h11112222);

      // jal-like link value
      step(6'b000011, 5'd0, 5'd31, 3'd3, 32'h0, 32'h0, 32'h3008, "t6.jal");
      chk("t6.pc8_const", bus.wd_w, 32'h3008);

      // randomised traffic over a small address window with varied high bits
      for (int n = 0; n < 400; n++) begin
         logic [31:0] ao;
         ao = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
         if ($urandom_range(0, 49) == 0) begin
            do_clr(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), $urandom, ao, "rnd.clr");
         end else begin
            step(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 3'($urandom_range(0, 3)), $urandom, ao, $urandom, "rnd");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
